gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 30 +++
 rtl/gcd_datapath.sv | 68 ++++++
 rtl/gcd_engine.sv | 114 +++++++++++
 tb/tb_gcd_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine: FSM states, algorithm select
// and the datapath operation codes the FSM issues each cycle.
package gcd_pkg;

  localparam int WL_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    EUCLID = 1'b0,
    STEIN  = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_LOAD     = 3'd1,
    OP_SWAP     = 3'd2,
    OP_SUB_AB   = 3'd3,
    OP_SUB_BA   = 3'd4,
    OP_SHIFT_AB = 3'd5,
    OP_SHIFT_A  = 3'd6,
    OP_SHIFT_B  = 3'd7
  } dp_op_t;

endpackage

// File: rtl/gcd_datapath.sv
// A/B/k registers with compare, subtract and shift units; performs one
// operation per cycle as selected by the controller and reports status flags.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  dp_op_t        op,
  input  logic [WL-1:0] a_in,
  input  logic [WL-1:0] b_in,
  output logic          a_zero,
  output logic          b_zero,
  output logic          a_lt_b,
  output logic          a_even,
  output logic          b_even,
  output logic [WL-1:0] a_val,
  output logic [WL-1:0] stein_res
);

  // k counts common factors of two; it never exceeds WL-1 for nonzero operands.
  localparam int KW = $clog2(WL) + 1;

  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic [KW-1:0] k;

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      k <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          a <= a_in;
          b <= b_in;
          k <= '0;
        end
        OP_SWAP: begin
          a <= b;
          b <= a;
        end
        OP_SUB_AB: a <= a - b;
        OP_SUB_BA: b <= b - a;
        OP_SHIFT_AB: begin
          a <= a >> 1;
          b <= b >> 1;
          k <= k + 1'b1;
        end
        OP_SHIFT_A: a <= a >> 1;
        OP_SHIFT_B: b <= b >> 1;
        default: ;
      endcase
    end
  end

  assign a_zero    = (a == '0);
  assign b_zero    = (b == '0);
  assign a_lt_b    = (a < b);
  assign a_even    = ~a[0];
  assign b_even    = ~b[0];
  assign a_val     = a;
  // The true gcd fits in WL bits, so truncating the shift loses nothing.
  assign stein_res = (a | b) << k;

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: Euclid (subtractive) or Stein (binary) algorithm, one step per
// cycle, with operand/result handshakes and a saturating CALC-cycle counter.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ops_val,
  output logic          ops_rdy,
  input  logic [WL-1:0] ops_a,
  input  logic [WL-1:0] ops_b,
  input  logic          ops_mode,
  output logic          res_val,
  input  logic          res_rdy,
  output logic [WL-1:0] res_data,
  output logic [CW-1:0] res_cyc,
  output state_t        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where val and rdy are both
  // 1; val never depends on rdy, and rdy/val are only ever asserted in
  // IDLE/DONE respectively, so inputs outside those states are ignored.

  state_t        state;
  state_t        state_nxt;
  mode_t         mode;
  dp_op_t        dp_op;
  logic [CW-1:0] cnt;
  logic [WL-1:0] res_q;
  logic          calc_done;
  logic          a_zero;
  logic          b_zero;
  logic          a_lt_b;
  logic          a_even;
  logic          b_even;
  logic [WL-1:0] a_val;
  logic [WL-1:0] stein_res;

  gcd_datapath #(.WL(WL)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .op        (dp_op),
    .a_in      (ops_a),
    .b_in      (ops_b),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_lt_b    (a_lt_b),
    .a_even    (a_even),
    .b_even    (b_even),
    .a_val     (a_val),
    .stein_res (stein_res)
  );

  assign calc_done = (mode == EUCLID) ? b_zero : (a_zero | b_zero);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ops_val) state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = DONE;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ops_rdy = (state == IDLE);
    res_val = (state == DONE);
    dp_op   = OP_HOLD;
    case (state)
      IDLE: if (ops_val) dp_op = OP_LOAD;
      CALC: begin
        if (calc_done)                dp_op = OP_HOLD;
        else if (mode == EUCLID)      dp_op = a_lt_b ? OP_SWAP : OP_SUB_AB;
        else if (a_even && b_even)    dp_op = OP_SHIFT_AB;
        else if (a_even)              dp_op = OP_SHIFT_A;
        else if (b_even)              dp_op = OP_SHIFT_B;
        else if (!a_lt_b)             dp_op = OP_SUB_AB;
        else                          dp_op = OP_SUB_BA;
      end
      default: dp_op = OP_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= EUCLID;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      if (state == IDLE && ops_val) begin
        mode <= mode_t'(ops_mode);
        cnt  <= '0;
      end else if (state == CALC && cnt != {CW{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
      if (state == CALC && calc_done)
        res_q <= (mode == STEIN) ? stein_res : a_val;
    end
  end

  assign res_data  = res_q;
  assign res_cyc   = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: directed vectors with hand-computed results, then
// pseudo-random pairs checked against a reference gcd and step-count model.
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int WL = 8;
  localparam int CW = 16;
  localparam int W  = WL + CW;

  logic          clk;
  logic          rst;
  logic          ops_val;
  logic          ops_rdy;
  logic [WL-1:0] ops_a;
  logic [WL-1:0] ops_b;
  logic          ops_mode;
  logic          res_val;
  logic          res_rdy;
  logic [WL-1:0] res_data;
  logic [CW-1:0] res_cyc;
  state_t        dbg_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit chk_next = 0;

  gcd_engine #(.WL(WL), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ops_val   (ops_val),
    .ops_rdy   (ops_rdy),
    .ops_a     (ops_a),
    .ops_b     (ops_b),
    .ops_mode  (ops_mode),
    .res_val   (res_val),
    .res_rdy   (res_rdy),
    .res_data  (res_data),
    .res_cyc   (res_cyc),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int model_cyc(input int a, input int b, input int m);
    int n = 0;
    while (n < 100000) begin
      n++;
      if (m == 0) begin
        if (b == 0) return n;
        else if (a < b) begin int t = a; a = b; b = t; end
        else a = a - b;
      end else begin
        if (a == 0 || b == 0) return n;
        else if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
        else if (a % 2 == 0) a = a / 2;
        else if (b % 2 == 0) b = b / 2;
        else if (a >= b) a = a - b;
        else b = b - a;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input int a, input int b, input int m,
                      input int eg, input int ec, input bit push);
    int t = 0;
    logic [31:0] g32;
    logic [31:0] c32;
    @(negedge clk);
    ops_a    = a[WL-1:0];
    ops_b    = b[WL-1:0];
    ops_mode = m[0];
    ops_val  = 1'b1;
    while (!ops_rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!ops_rdy) begin
      check("ops_accept_timeout", 0, 1);
    end else if (push) begin
      g32 = eg;
      c32 = ec;
      exp_q.push_back({g32[WL-1:0], c32[CW-1:0]});
    end
    @(negedge clk);
    ops_val = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    res_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        check("ops_rdy_after_result", ops_rdy, 1);
        check("res_val_after_result", res_val, 0);
        chk_next = 0;
      end
      case (rdy_mode)
        0:       res_rdy = 1'b1;
        1:       res_rdy = 1'($urandom_range(0, 1));
        default: res_rdy = 1'b0;
      endcase
      if (!rst && res_val && res_rdy) begin
        pops++;
        check("ops_rdy_in_done", ops_rdy, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got data=%0d cyc=%0d expected none", res_data, res_cyc);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e[W-1:CW]);
          check("res_cyc", res_cyc, e[CW-1:0]);
        end
        chk_next = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int va[11] = '{15, 12, 12, 0, 0, 7, 7, 0, 0, 255, 255};
  int vb[11] = '{ 5,  8,  8, 0, 0, 0, 0, 7, 7, 255, 255};
  int vm[11] = '{ 0,  1,  0, 0, 1, 0, 1, 0, 1,   0,   1};
  int vg[11] = '{ 5,  4,  4, 0, 0, 7, 7, 7, 7, 255, 255};
  int vc[11] = '{ 5,  7,  6, 1, 1, 1, 1, 2, 1,   3,   2};

  initial begin
    int t;
    int p0;
    int ra;
    int rb;
    int rm;
    rst      = 1'b1;
    ops_val  = 1'b0;
    ops_a    = '0;
    ops_b    = '0;
    ops_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ops_rdy", ops_rdy, 1);
    check("rst_res_val", res_val, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_cyc", res_cyc, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // Directed vectors, hand-computed gcd and CALC-cycle counts.
    rdy_mode = 0;
    for (int i = 0; i < 11; i++) send(va[i], vb[i], vm[i], vg[i], vc[i], 1'b1);
    wait_drain();

    // Backpressure: gcd(36,24) Euclid = 12 after 6 CALC cycles.
    rdy_mode = 2;
    send(36, 24, 0, 12, 6, 1'b1);
    t = 0;
    while (!res_val && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_res_val_seen", res_val, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", res_data, 12);
      check("bp_cyc_stable", res_cyc, 6);
      check("bp_res_val", res_val, 1);
      check("bp_ops_rdy", ops_rdy, 0);
      ops_a   = WL'($urandom_range(0, 255));
      ops_b   = WL'($urandom_range(0, 255));
      ops_val = i[0];
    end
    ops_val  = 1'b0;
    p0       = pops;
    rdy_mode = 0;
    t = 0;
    while (pops == p0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("bp_one_consumed", pops - p0, 1);
    check("bp_res_val_after", res_val, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a long Euclid gcd(255,1).
    send(255, 1, 0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_calc_state", dbg_state, CALC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", dbg_state, IDLE);
    check("abort_ops_rdy", ops_rdy, 1);
    check("abort_res_val", res_val, 0);
    check("abort_res_cyc", res_cyc, 0);
    repeat (3) @(negedge clk);
    check("abort_no_result", res_val, 0);
    send(255, 17, 1, 17, model_cyc(255, 17, 1), 1'b1);
    wait_drain();

    // Back-to-back pairs with random result backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rm = $urandom_range(0, 1);
      if (i == 0) begin ra = 255; rb = 254; end
      if (i == 1) begin ra = 128; rb = 64; end
      send(ra, rb, rm, ref_gcd(ra, rb), model_cyc(ra, rb, rm), 1'b1);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    check("final_res_val", res_val, 0);
    check("final_ops_rdy", ops_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
